// File: rtl/count_sync_display_if.sv
// Accepted-count bus between the ripple counter sync block and its consumers.
// Raw ripple count in; filtered count, events and display drive out.
interface count_sync_display_if;
  logic [3:0] count_in;
  logic [3:0] count_out;
  logic       count_valid;
  logic       step_pulse;
  logic       wrap_pulse;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output count_in,
    input  count_out, count_valid,
    input  step_pulse, wrap_pulse,
    input  seg, an
  );

  modport slave (
    input  count_in,
    output count_out, count_valid,
    output step_pulse, wrap_pulse,
    output seg, an
  );
endinterface

// File: rtl/count_sync_display.sv
// Synchronizes and debounces a ripple counter, emits step/wrap events
// and drives a 2-digit multiplexed active-low 7-segment display.
module count_sync_display #(
  parameter int STABLE_CYCLES = 2,
  parameter int REFRESH_BITS  = 16
) (
  input logic clk,
  input logic rst,
  count_sync_display_if.slave bus
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  logic [3:0] s1, s2;
  logic [3:0] cand, stab;
  logic [3:0] cnt;
  logic       valid;
  logic       step_q, wrap_q;
  logic [REFRESH_BITS-1:0] refresh;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;

  logic       tens;
  logic [3:0] units;
  logic       sel_tens;
  logic       accept;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tens     = (cnt >= 4'd10);
  assign units    = tens ? cnt - 4'd10 : cnt;
  assign sel_tens = refresh[REFRESH_BITS-1];
  assign accept   = (stab == STAB_MAX)
                  && (!valid || cand != cnt);

  // Leading zero of the tens digit is blanked.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    unique case (1'b1)
      !valid: begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
      end
      valid && !sel_tens: begin
        an_d  = 4'b1110;
        seg_d = enc(units);
      end
      valid && sel_tens && tens: begin
        an_d  = 4'b1101;
        seg_d = enc(4'd1);
      end
      valid && sel_tens && !tens: begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      cand    <= '0;
      stab    <= '0;
      cnt     <= '0;
      valid   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      refresh <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
    end else begin
      s1 <= bus.count_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        stab <= 4'd1;
      end else if (stab < STAB_MAX) begin
        stab <= stab + 4'd1;
      end
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (accept) begin
        cnt    <= cand;
        valid  <= 1'b1;
        step_q <= valid && (cand == cnt + 4'd1);
        wrap_q <= valid && (cnt == 4'd15)
               && (cand == 4'd0);
      end
      refresh <= refresh + 1'b1;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count_out   = cnt;
  assign bus.count_valid = valid;
  assign bus.step_pulse  = step_q;
  assign bus.wrap_pulse  = wrap_q;
  assign bus.seg         = seg_q;
  assign bus.an          = an_q;

endmodule

// File: tb/tb_count_sync_display.sv
// Bench for count_sync_display: acceptance events scoreboarded,
// latency, glitch, display and reset behaviour checked per scenario.
module tb_count_sync_display;

  typedef struct {
    logic [3:0] v;
    logic       s;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic [3:0] prev_out;
  logic       prev_valid;

  count_sync_display_if bus();

  count_sync_display #(
    .STABLE_CYCLES(2),
    .REFRESH_BITS (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every acceptance must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      prev_out   <= bus.count_out;
      prev_valid <= 1'b0;
    end else begin
      if (bus.count_valid && (!prev_valid || bus.count_out != prev_out)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got count_out=%0d step=%b wrap=%b, none expected",
                   bus.count_out, bus.step_pulse, bus.wrap_pulse);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.count_out !== e.v || bus.step_pulse !== e.s
              || bus.wrap_pulse !== e.w) begin
            errors++;
            $display("FAIL sb_event: got %0d/%b/%b, expected %0d/%b/%b",
                     bus.count_out, bus.step_pulse, bus.wrap_pulse,
                     e.v, e.s, e.w);
          end
        end
      end else begin
        checks++;
        if (bus.step_pulse !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
          errors++;
          $display("FAIL sb_idle_pulse: step=%b wrap=%b, expected 0/0",
                   bus.step_pulse, bus.wrap_pulse);
        end
      end
      prev_out   <= bus.count_out;
      prev_valid <= bus.count_valid;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] v, input logic s, input logic w);
    exp_t e;
    e.v = v;
    e.s = s;
    e.w = w;
    q.push_back(e);
  endtask

  task automatic goto_val(input logic [3:0] v);
    push(v, 1'b0, 1'b0);
    bus.count_in = v;
    step(6);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events pending, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    bus.count_in = 4'd0;
    rst = 1'b1;
    step(2);
    checks++;
    if (bus.count_out !== 4'd0 || bus.count_valid !== 1'b0
        || bus.an !== 4'b1111 || bus.seg !== 7'h7F
        || bus.step_pulse !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%0d valid=%b an=%b seg=%h, expected 0 0 1111 7f",
               bus.count_out, bus.count_valid, bus.an, bus.seg);
    end
    push(4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(2);
    checks++;
    if (bus.count_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_early_valid: valid=%b at edge 2, expected 0", bus.count_valid);
    end
    step();
    checks++;
    if (bus.count_valid !== 1'b1 || bus.count_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_first_accept: valid=%b out=%0d at edge 3, expected 1 0",
               bus.count_valid, bus.count_out);
    end
    drain("reset");
  endtask

  task automatic test_step();
    goto_val(4'd4);
    push(4'd5, 1'b1, 1'b0);
    bus.count_in = 4'd5;
    step(4);
    checks++;
    if (bus.count_out !== 4'd4) begin
      errors++;
      $display("FAIL step_early: out=%0d at edge 4, expected 4", bus.count_out);
    end
    step();
    checks++;
    if (bus.count_out !== 4'd5 || bus.step_pulse !== 1'b1 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL step_edge5: out=%0d step=%b wrap=%b, expected 5 1 0",
               bus.count_out, bus.step_pulse, bus.wrap_pulse);
    end
    step();
    checks++;
    if (bus.step_pulse !== 1'b0) begin
      errors++;
      $display("FAIL step_one_cycle: step=%b after edge 6, expected 0", bus.step_pulse);
    end
    drain("step");
  endtask

  task automatic test_wrap();
    goto_val(4'd15);
    push(4'd0, 1'b1, 1'b1);
    bus.count_in = 4'd0;
    step(5);
    checks++;
    if (bus.count_out !== 4'd0 || bus.step_pulse !== 1'b1 || bus.wrap_pulse !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge5: out=%0d step=%b wrap=%b, expected 0 1 1",
               bus.count_out, bus.step_pulse, bus.wrap_pulse);
    end
    step();
    checks++;
    if (bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wrap_one_cycle: wrap=%b after edge 6, expected 0", bus.wrap_pulse);
    end
    drain("wrap");
  endtask

  task automatic test_glitch();
    goto_val(4'd7);
    push(4'd8, 1'b1, 1'b0);
    bus.count_in = 4'd6;
    step();
    bus.count_in = 4'd4;
    step();
    bus.count_in = 4'd8;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus.count_out !== 4'd7 && bus.count_out !== 4'd8) begin
        errors++;
        $display("FAIL glitch_leak: out=%0d, expected 7 or 8", bus.count_out);
      end
    end
    checks++;
    if (bus.count_out !== 4'd8) begin
      errors++;
      $display("FAIL glitch_final: out=%0d, expected 8", bus.count_out);
    end
    drain("glitch");
  endtask

  task automatic test_display();
    bit seen_u, seen_t, seen_b;
    goto_val(4'd12);
    seen_u = 0;
    seen_t = 0;
    for (int i = 0; i < 20 && !(seen_u && seen_t); i++) begin
      step();
      if (bus.an == 4'b1110) begin
        seen_u = 1;
        checks++;
        if (bus.seg !== 7'h24) begin
          errors++;
          $display("FAIL disp12_units: seg=%h, expected 24", bus.seg);
        end
      end else if (bus.an == 4'b1101) begin
        seen_t = 1;
        checks++;
        if (bus.seg !== 7'h79) begin
          errors++;
          $display("FAIL disp12_tens: seg=%h, expected 79", bus.seg);
        end
      end
    end
    checks++;
    if (!(seen_u && seen_t)) begin
      errors++;
      $display("FAIL disp12_phases: units=%b tens=%b seen, expected both", seen_u, seen_t);
    end
    goto_val(4'd3);
    seen_u = 0;
    seen_b = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.an == 4'b1110) begin
        seen_u = 1;
        if (bus.seg !== 7'h30) begin
          errors++;
          $display("FAIL disp3_units: seg=%h, expected 30", bus.seg);
        end
      end else if (bus.an == 4'b1111) begin
        seen_b = 1;
      end else begin
        errors++;
        $display("FAIL disp3_an: an=%b, expected 1110 or 1111", bus.an);
      end
    end
    checks++;
    if (!(seen_u && seen_b)) begin
      errors++;
      $display("FAIL disp3_phases: units=%b blank=%b seen, expected both", seen_u, seen_b);
    end
    drain("display");
  endtask

  task automatic test_reset_mid();
    goto_val(4'd2);
    bus.count_in = 4'd3;
    step(3);
    rst = 1'b1;
    step();
    checks++;
    if (bus.count_out !== 4'd0 || bus.count_valid !== 1'b0
        || bus.an !== 4'b1111 || bus.seg !== 7'h7F
        || bus.step_pulse !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: out=%0d valid=%b an=%b seg=%h, expected 0 0 1111 7f",
               bus.count_out, bus.count_valid, bus.an, bus.seg);
    end
    // Synchronizer restarts at 0, so 0 qualifies before 3 arrives.
    push(4'd0, 1'b0, 1'b0);
    push(4'd3, 1'b0, 1'b0);
    rst = 1'b0;
    step(8);
    checks++;
    if (bus.count_out !== 4'd3 || bus.count_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_final: out=%0d valid=%b, expected 3 1",
               bus.count_out, bus.count_valid);
    end
    drain("rstmid");
  endtask

  initial begin
    bus.count_in = 4'd0;
    test_reset();
    test_step();
    test_wrap();
    test_glitch();
    test_display();
    test_reset_mid();
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sync_display.md
Name: count_sync_display

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter.
- Brings the ripple `count` bus into the system clock domain with a 2-flop synchronizer, then applies a stability filter so that ripple transients are never accepted.
- Emits one-cycle step and wrap event pulses.
- Drives a 2-digit multiplexed, active-low 7-segment display showing the count in decimal (0–15).

Parameters:
- STABLE_CYCLES, 2, consecutive synchronized cycles a value must hold before acceptance (range 1..15).
- REFRESH_BITS, 16, width of the display refresh counter; the digit alternates every 2^(REFRESH_BITS-1) cycles.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- count_in  input  4  raw ripple-counter value, asynchronous to clk.
- count_out  output  4  filtered, accepted count.
- count_valid  output  1  high once the first value has been accepted after reset.
- step_pulse  output  1  one-cycle pulse when the accepted value equals the previous value + 1 mod 16.
- wrap_pulse  output  1  one-cycle pulse on an accepted 15→0 transition.
- seg  output  7  segment cathodes, active low, bit order {g,f,e,d,c,b,a}.
- an  output  4  digit anodes, active low; an[0] = units, an[1] = tens, an[3:2] held high.

Behaviour:
- Reset, evaluated on a clk edge with rst=1, clears:
  - s1, s2, cand, stab, count_out, refresh counter → 0
  - count_valid, step_pulse, wrap_pulse → 0
  - an → 4'b1111, seg → 7'h7F
- Reset mid-operation discards all state, including any partially qualified candidate.
- Synchronizer: s1 <= count_in; s2 <= s1. No other logic samples count_in.
- Stability filter, evaluated every cycle:
  - If s2 != cand: cand <= s2, stab <= 1.
  - Else if stab < STABLE_CYCLES: stab <= stab + 1.
  - Else: stab holds at STABLE_CYCLES (saturates).
- Acceptance: when stab == STABLE_CYCLES and (count_valid == 0 or cand != count_out):
  - count_out <= cand, count_valid <= 1.
- Pulses are registered in the same edge as the acceptance:
  - step_pulse = count_valid && (cand == count_out + 1 mod 16).
  - wrap_pulse = count_valid && count_out == 15 && cand == 0; step_pulse is also high in this case.
  - A non-+1 change (jump) updates count_out with no pulses.
  - The first acceptance after reset produces no pulses.
  - Both pulses are low in all other cycles.
- Latency: when count_in changes and then holds, count_out updates on clock edge 3+STABLE_CYCLES (edge 5 at default).
- Glitch rejection:
  - Any s2 value present for fewer than STABLE_CYCLES consecutive cycles is never accepted.
  - A glitch back to the current count_out re-qualifies that value silently, with no update and no pulse.
- After reset with count_in held constant, count_valid rises on edge STABLE_CYCLES+1.
- Display:
  - refresh counter increments every cycle and wraps.
  - MSB = 0 selects units; MSB = 1 selects tens.
  - Decimal split: tens = (count_out >= 10); units = tens ? count_out - 10 : count_out.
  - Units active: an = 4'b1110.
  - Tens active: an = 4'b1101 when tens = 1; an = 4'b1111 (leading zero blanked) when tens = 0.
  - While count_valid = 0: an = 4'b1111.
  - seg/an are registered: one cycle behind count_out and the refresh MSB.
- Segment encodings (active low, {g..a}):
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10
- Widths: all count arithmetic is 4-bit modulo 16; stab is 4 bits; refresh is REFRESH_BITS bits.

Test Plan:
1. Reset, count_in = 0 held → count_valid = 1 on edge 3 after rst release; count_out = 0; step_pulse and wrap_pulse never asserted.
2. Valid state with count_out = 4, count_in steps 4→5 and holds → count_out = 5 on edge 5; step_pulse high for exactly that one cycle; wrap_pulse = 0.
3. count_out = 15, count_in → 0 held → count_out = 0 on edge 5; step_pulse = 1 and wrap_pulse = 1 for one cycle.
4. count_out = 7, ripple transient 7→6→4→8, with 6 and 4 each present for 1 cycle and 8 held → count_out goes 7→8 directly; one step_pulse; values 6 and 4 never appear.
5. count_out = 12 with REFRESH_BITS = 4 → units phase: an = 4'b1110, seg = 7'h24; tens phase: an = 4'b1101, seg = 7'h79; count_out = 3 → tens phase an = 4'b1111.
6. Count advancing 2→3 with rst asserted for 1 cycle at the cycle stab reaches 1 → outputs return to reset values; the candidate is dropped; with 3 held after release, count_valid = 1 and count_out = 3 with no pulses.
